branch_ctrl: RTL and testbench

Multi-cycle branch resolution controller for the RV32I core. It accepts one conditional-branch request from decode and drives the shared `branch_comp` comparator (`BrUn`, `DataA`, `DataB` → `BrLT`, `BrEq`). It evaluates the funct3 condition and produces a one-cycle resolution pulse with `PCSel` and the next-PC target for the fetch stage. It also keeps a saturating taken-branch performance counter.

---
 rtl/branch_ctrl.sv | 145 ++++++++++++++
 tb/tb_branch_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_ctrl.sv
// branch_ctrl: multi-cycle conditional-branch resolution controller.
// Accepts one branch from decode, drives the shared branch comparator with
// registered operands, then resolves taken/not-taken one cycle later and
// emits a single-cycle resolution pulse with the next-PC target.
module branch_ctrl #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             BrReq,
  input  logic [2:0]       Funct3,
  input  logic [XLEN-1:0]  RS1,
  input  logic [XLEN-1:0]  RS2,
  input  logic [XLEN-1:0]  PC,
  input  logic [XLEN-1:0]  Imm,
  input  logic             Flush,
  input  logic             BrLT,
  input  logic             BrEq,
  output logic             BrUn,
  output logic [XLEN-1:0]  DataA,
  output logic [XLEN-1:0]  DataB,
  output logic             BrBusy,
  output logic             BrDone,
  output logic             PCSel,
  output logic [XLEN-1:0]  BrTarget,
  output logic             BrIllegal,
  output logic             BrMisalign,
  output logic [CNT_W-1:0] TakenCount
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [2:0]       funct3_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  imm_q;
  logic [XLEN-1:0]  data_a_q;
  logic [XLEN-1:0]  data_b_q;
  logic             br_un_q;
  logic             done_q;
  logic             pcsel_q;
  logic             illegal_q;
  logic             misalign_q;
  logic [XLEN-1:0]  target_q;
  logic [CNT_W-1:0] cnt_q;

  logic             taken_d;
  logic             illegal_d;
  logic             misalign_d;
  logic             pcsel_d;
  logic [XLEN-1:0]  jump_tgt_d;
  logic [XLEN-1:0]  fall_tgt_d;
  logic [XLEN-1:0]  target_d;
  logic [CNT_W-1:0] cnt_d;

  // Resolve the latched branch from the comparator flags (used only in CMP).
  always_comb begin
    taken_d = 1'b0;
    case (funct3_q)
      3'b000:         taken_d = BrEq;
      3'b001:         taken_d = ~BrEq;
      3'b100, 3'b110: taken_d = BrLT;
      3'b101, 3'b111: taken_d = ~BrLT;
      default:        taken_d = 1'b0;
    endcase
    illegal_d  = (funct3_q[2:1] == 2'b01);
    jump_tgt_d = pc_q + imm_q;
    fall_tgt_d = pc_q + XLEN'(4);
    // A misaligned taken branch falls through; the trap unit acts on BrMisalign.
    misalign_d = taken_d & (jump_tgt_d[1:0] != 2'b00);
    pcsel_d    = taken_d & ~illegal_d & ~misalign_d;
    target_d   = pcsel_d ? jump_tgt_d : fall_tgt_d;
    cnt_d      = (pcsel_d && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + CNT_W'(1) : cnt_q;
  end

  // Control FSM with registered comparator operands and resolution outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      funct3_q   <= 3'b000;
      pc_q       <= '0;
      imm_q      <= '0;
      data_a_q   <= '0;
      data_b_q   <= '0;
      br_un_q    <= 1'b0;
      done_q     <= 1'b0;
      pcsel_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      target_q   <= '0;
      cnt_q      <= '0;
    end else begin
      done_q     <= 1'b0;
      pcsel_q    <= 1'b0;
      illegal_q  <= 1'b0;
      misalign_q <= 1'b0;
      case (state_q)
        CMP: begin
          if (Flush) begin
            state_q <= IDLE;
          end else begin
            state_q    <= DONE;
            done_q     <= 1'b1;
            pcsel_q    <= pcsel_d;
            illegal_q  <= illegal_d;
            misalign_q <= misalign_d;
            target_q   <= target_d;
            cnt_q      <= cnt_d;
          end
        end
        default: begin
          // IDLE and DONE both accept a new request; Flush drops it.
          if (Flush || !BrReq) begin
            state_q <= IDLE;
          end else begin
            state_q  <= CMP;
            data_a_q <= RS1;
            data_b_q <= RS2;
            br_un_q  <= Funct3[1];
            funct3_q <= Funct3;
            pc_q     <= PC;
            imm_q    <= Imm;
          end
        end
      endcase
    end
  end

  assign BrUn       = br_un_q;
  assign DataA      = data_a_q;
  assign DataB      = data_b_q;
  assign BrBusy     = (state_q == CMP);
  assign BrDone     = done_q;
  assign PCSel      = pcsel_q;
  assign BrTarget   = target_q;
  assign BrIllegal  = illegal_q;
  assign BrMisalign = misalign_q;
  assign TakenCount = cnt_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// Testbench for branch_ctrl: models the branch comparator, applies a table
// of directed branches, hand-written abort/back-to-back sequences, random
// branches checked against a behavioural model, and counter saturation.
module tb_branch_ctrl;

  localparam int XLEN  = 32;
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic             clk = 1'b0;
  logic             rst;
  logic             BrReq;
  logic [2:0]       Funct3;
  logic [XLEN-1:0]  RS1, RS2, PC, Imm;
  logic             Flush;
  logic             BrLT, BrEq;
  logic             BrUn;
  logic [XLEN-1:0]  DataA, DataB;
  logic             BrBusy, BrDone, PCSel, BrIllegal, BrMisalign;
  logic [XLEN-1:0]  BrTarget;
  logic [CNT_W-1:0] TakenCount;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;

  always #5 clk = ~clk;

  // Shared comparator in the environment.
  assign BrEq = (DataA == DataB);
  assign BrLT = BrUn ? (DataA < DataB) : ($signed(DataA) < $signed(DataB));

  branch_ctrl #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .BrReq(BrReq), .Funct3(Funct3),
    .RS1(RS1), .RS2(RS2), .PC(PC), .Imm(Imm), .Flush(Flush),
    .BrLT(BrLT), .BrEq(BrEq), .BrUn(BrUn), .DataA(DataA), .DataB(DataB),
    .BrBusy(BrBusy), .BrDone(BrDone), .PCSel(PCSel), .BrTarget(BrTarget),
    .BrIllegal(BrIllegal), .BrMisalign(BrMisalign), .TakenCount(TakenCount)
  );

  typedef struct {
    logic       un;
    logic       pcsel;
    logic       ill;
    logic       mis;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, pc, imm;
    exp_t        e;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Architectural branch semantics straight from the ISA rules.
  function automatic exp_t model(input logic [2:0] f3, input logic [31:0] a, b, pc, imm);
    exp_t  r;
    bit    taken;
    logic [31:0] jt;
    case (f3)
      3'd0: taken = (a == b);
      3'd1: taken = (a != b);
      3'd4: taken = ($signed(a) <  $signed(b));
      3'd5: taken = ($signed(a) >= $signed(b));
      3'd6: taken = (a <  b);
      3'd7: taken = (a >= b);
      default: taken = 0;
    endcase
    jt      = pc + imm;
    r.un    = f3[1];
    r.ill   = (f3 == 3'd2) || (f3 == 3'd3);
    r.mis   = taken && (jt[1:0] != 2'b00);
    r.pcsel = taken && !r.mis;
    r.tgt   = r.pcsel ? jt : pc + 32'd4;
    return r;
  endfunction

  task automatic drive(input logic [2:0] f3, input logic [31:0] a, b, pc, imm);
    Funct3 = f3; RS1 = a; RS2 = b; PC = pc; Imm = imm; BrReq = 1'b1;
  endtask

  task automatic cnt_update(input logic pcsel);
    if (pcsel && exp_cnt < int'(CNT_MAX)) exp_cnt++;
  endtask

  // Full branch from IDLE: CMP cycle checks, DONE cycle checks, pulse drop.
  task automatic run_branch(input string nm, input logic [2:0] f3,
                            input logic [31:0] a, b, pc, imm, input exp_t e);
    drive(f3, a, b, pc, imm);
    step();
    BrReq = 1'b0;
    chk({nm, ".busy"},  {31'd0, BrBusy}, 32'd1);
    chk({nm, ".un"},    {31'd0, BrUn},   {31'd0, e.un});
    chk({nm, ".dataA"}, DataA, a);
    chk({nm, ".dataB"}, DataB, b);
    chk({nm, ".done_cmp"}, {31'd0, BrDone}, 32'd0);
    step();
    cnt_update(e.pcsel);
    chk({nm, ".done"},  {31'd0, BrDone},     32'd1);
    chk({nm, ".pcsel"}, {31'd0, PCSel},      {31'd0, e.pcsel});
    chk({nm, ".ill"},   {31'd0, BrIllegal},  {31'd0, e.ill});
    chk({nm, ".mis"},   {31'd0, BrMisalign}, {31'd0, e.mis});
    chk({nm, ".tgt"},   BrTarget, e.tgt);
    chk({nm, ".cnt"},   32'(TakenCount), 32'(exp_cnt));
    chk({nm, ".busy_done"}, {31'd0, BrBusy}, 32'd0);
    step();
    chk({nm, ".done_drop"},  {31'd0, BrDone}, 32'd0);
    chk({nm, ".pcsel_drop"}, {31'd0, PCSel},  32'd0);
    chk({nm, ".tgt_hold"},   BrTarget, e.tgt);
  endtask

  vec_t vecs[9];

  initial begin
    vec_t  v;
    exp_t  e;
    logic [31:0] a, b, pc, imm;
    logic [2:0]  f3;

    //            f3    rs1           rs2           pc            imm           un  pcsel ill mis tgt
    vecs[0] = '{3'd0, 32'd5,        32'd5,        32'h100,      32'h20,       '{0, 1, 0, 0, 32'h120}};
    vecs[1] = '{3'd6, 32'hFFFFFFFF, 32'd0,        32'h200,      32'h40,       '{1, 0, 0, 0, 32'h204}};
    vecs[2] = '{3'd4, 32'hFFFFFFFF, 32'd0,        32'h200,      32'h40,       '{0, 1, 0, 0, 32'h240}};
    vecs[3] = '{3'd5, 32'hFFFFFFFB, 32'hFFFFFFF6, 32'hFFFFFFF0, 32'h20,       '{0, 1, 0, 0, 32'h10}};
    vecs[4] = '{3'd1, 32'd7,        32'd7,        32'hFFFFFFFC, 32'h10,       '{0, 0, 0, 0, 32'h0}};
    vecs[5] = '{3'd2, 32'd1,        32'd1,        32'h300,      32'h8,        '{1, 0, 1, 0, 32'h304}};
    vecs[6] = '{3'd0, 32'd3,        32'd3,        32'h400,      32'h6,        '{0, 0, 0, 1, 32'h404}};
    vecs[7] = '{3'd7, 32'd0,        32'hFFFFFFFF, 32'h500,      32'hFFFFFF00, '{1, 0, 0, 0, 32'h504}};
    vecs[8] = '{3'd3, 32'd9,        32'd2,        32'h600,      32'h10,       '{1, 0, 1, 0, 32'h604}};

    rst = 1'b1; BrReq = 1'b0; Flush = 1'b0;
    Funct3 = '0; RS1 = '0; RS2 = '0; PC = '0; Imm = '0;
    step(); step();
    rst = 1'b0;
    chk("rst.done",  {31'd0, BrDone}, 32'd0);
    chk("rst.busy",  {31'd0, BrBusy}, 32'd0);
    chk("rst.tgt",   BrTarget, 32'd0);
    chk("rst.dataA", DataA, 32'd0);
    chk("rst.cnt",   32'(TakenCount), 32'd0);

    for (int i = 0; i < 9; i++) begin
      v = vecs[i];
      run_branch($sformatf("vec%0d", i), v.f3, v.rs1, v.rs2, v.pc, v.imm, v.e);
    end

    // Flush during CMP: no pulse, back to IDLE, count unchanged.
    drive(3'd0, 32'd1, 32'd1, 32'h700, 32'h4);
    step();
    BrReq = 1'b0; Flush = 1'b1;
    step();
    Flush = 1'b0;
    chk("flush_cmp.done", {31'd0, BrDone}, 32'd0);
    chk("flush_cmp.busy", {31'd0, BrBusy}, 32'd0);
    step();
    chk("flush_cmp.done2", {31'd0, BrDone}, 32'd0);
    chk("flush_cmp.cnt",   32'(TakenCount), 32'(exp_cnt));

    // Flush together with BrReq in IDLE: request dropped.
    drive(3'd0, 32'd1, 32'd1, 32'h700, 32'h4);
    Flush = 1'b1;
    step();
    BrReq = 1'b0; Flush = 1'b0;
    chk("flush_req.busy", {31'd0, BrBusy}, 32'd0);
    step();
    chk("flush_req.done", {31'd0, BrDone}, 32'd0);

    // Back-to-back: second request sampled during DONE.
    drive(3'd0, 32'd2, 32'd2, 32'h800, 32'h40);
    step();
    BrReq = 1'b0;
    step();
    cnt_update(1'b1);
    chk("b2b.done1", {31'd0, BrDone}, 32'd1);
    chk("b2b.tgt1",  BrTarget, 32'h840);
    drive(3'd1, 32'd2, 32'd3, 32'h900, 32'h80);
    step();
    BrReq = 1'b0;
    chk("b2b.busy2",  {31'd0, BrBusy}, 32'd1);
    chk("b2b.gap",    {31'd0, BrDone}, 32'd0);
    chk("b2b.dataB2", DataB, 32'd3);
    step();
    cnt_update(1'b1);
    chk("b2b.done2", {31'd0, BrDone}, 32'd1);
    chk("b2b.tgt2",  BrTarget, 32'h980);
    // Flush in DONE does not retract the pulse already on the outputs.
    Flush = 1'b1;
    #2;
    chk("flush_done.pulse", {31'd0, BrDone}, 32'd1);
    chk("flush_done.cnt",   32'(TakenCount), 32'(exp_cnt));
    step();
    Flush = 1'b0;
    chk("flush_done.after", {31'd0, BrDone}, 32'd0);

    // Random branches against the behavioural model.
    for (int i = 0; i < 150; i++) begin
      f3  = 3'($urandom_range(0, 7));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ 32'h8000_0000;
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      imm = $urandom;
      if ($urandom_range(0, 3) != 0) imm[1:0] = 2'b00;
      e = model(f3, a, b, pc, imm);
      run_branch($sformatf("rnd%0d", i), f3, a, b, pc, imm, e);
    end

    // Reset during CMP: everything back to zero, branch discarded.
    drive(3'd0, 32'd4, 32'd4, 32'hA00, 32'h8);
    step();
    BrReq = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    exp_cnt = 0;
    chk("rst_cmp.done",  {31'd0, BrDone}, 32'd0);
    chk("rst_cmp.pcsel", {31'd0, PCSel},  32'd0);
    chk("rst_cmp.busy",  {31'd0, BrBusy}, 32'd0);
    chk("rst_cmp.un",    {31'd0, BrUn},   32'd0);
    chk("rst_cmp.dataA", DataA, 32'd0);
    chk("rst_cmp.dataB", DataB, 32'd0);
    chk("rst_cmp.tgt",   BrTarget, 32'd0);
    chk("rst_cmp.cnt",   32'(TakenCount), 32'd0);
    step();
    chk("rst_cmp.done2", {31'd0, BrDone}, 32'd0);

    // Counter saturation: two more taken branches than the counter can hold.
    for (int i = 0; i < int'(CNT_MAX) + 2; i++) begin
      drive(3'd0, 32'd1, 32'd1, 32'h1000, 32'h10);
      step();
      BrReq = 1'b0;
      step();
      cnt_update(1'b1);
      if (i == int'(CNT_MAX) - 1) chk("sat.reach", 32'(TakenCount), 32'(CNT_MAX));
    end
    chk("sat.hold", 32'(TakenCount), 32'(CNT_MAX));
    chk("sat.model", 32'(TakenCount), 32'(exp_cnt));
    chk("sat.pcsel", {31'd0, PCSel}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
